lcv_div_multi_cycle: RTL and testbench



---
 rtl/lcv_div_pkg.sv | 29 ++
 rtl/lcv_div_step.sv | 29 ++
 rtl/lcv_div_multi_cycle.sv | 142 ++++++++++++++
 tb/tb_lcv_div_multi_cycle.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lcv_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcv_div_pkg
//  Purpose  : Shared FSM state type and sizing helpers for the iterative divider.
//  Revision : 1.0 - initial release
// ============================================================================
package lcv_div_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ITER  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } lcv_div_state_e;

   localparam int LCV_DIV_MAX_WIDTH = 64;

   function automatic int lcv_div_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Most negative two's-complement value of a width-bit word, zero-extended.
   function automatic logic [LCV_DIV_MAX_WIDTH-1:0] lcv_div_min_val(input int width);
      return {{(LCV_DIV_MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcv_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : lcv_div_step
//  Purpose  : One radix-2 restoring division step (shift in, trial subtract).
//  Revision : 1.0 - initial release
// ============================================================================
module lcv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             quot_bit_o
);

   logic [WIDTH:0] rem_shift_w;
   logic [WIDTH:0] trial_w;

   // The partial remainder stays below the divisor, so either result fits WIDTH bits.
   always_comb begin
      rem_shift_w = {rem_i, bit_i};
      trial_w     = rem_shift_w - {1'b0, div_i};
      quot_bit_o  = ~trial_w[WIDTH];
      rem_o       = trial_w[WIDTH] ? rem_shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/lcv_div_multi_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : lcv_div_multi_cycle
//  Purpose  : Iterative signed/unsigned restoring divider, one quotient bit per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module lcv_div_multi_cycle
   import lcv_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp_valid,
   output logic             inp_ready,
   input  logic [WIDTH-1:0] inp_a,
   input  logic [WIDTH-1:0] inp_b,
   input  logic             inp_signed,
   output logic             outp_valid,
   input  logic             outp_ready,
   output logic [WIDTH-1:0] outp_quot,
   output logic [WIDTH-1:0] outp_rem,
   output logic             outp_div_by_zero
);

   localparam int               CNT_W    = lcv_div_cnt_w(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(lcv_div_min_val(WIDTH));
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   lcv_div_state_e   state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q;
   logic             signed_q;
   logic [WIDTH-1:0] div_q, shift_q, prem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             quot_neg_q, rem_neg_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic             dbz_q;

   logic             a_neg_w, b_neg_w, b_zero_w, ovf_w;
   logic [WIDTH-1:0] a_abs_w, b_abs_w;
   logic [WIDTH-1:0] step_rem_w;
   logic             step_qbit_w;

   assign a_neg_w  = signed_q & a_q[WIDTH-1];
   assign b_neg_w  = signed_q & b_q[WIDTH-1];
   assign a_abs_w  = a_neg_w ? -a_q : a_q;
   assign b_abs_w  = b_neg_w ? -b_q : b_q;
   assign b_zero_w = (b_q == '0);
   assign ovf_w    = signed_q & (a_q == MIN_VAL) & (b_q == '1);

   lcv_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i      (prem_q),
      .bit_i      (shift_q[WIDTH-1]),
      .div_i      (div_q),
      .rem_o      (step_rem_w),
      .quot_bit_o (step_qbit_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (inp_valid) state_d = ST_PREP;
         ST_PREP:  state_d = (b_zero_w || ovf_w) ? ST_DONE : ST_ITER;
         ST_ITER:  if (cnt_q == CNT_LAST) state_d = ST_FIXUP;
         ST_FIXUP: state_d = ST_DONE;
         ST_DONE:  if (outp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The shift register starts as |a| and fills with quotient bits as dividend bits leave.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         signed_q   <= 1'b0;
         div_q      <= '0;
         shift_q    <= '0;
         prem_q     <= '0;
         cnt_q      <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inp_valid) begin
                  a_q      <= inp_a;
                  b_q      <= inp_b;
                  signed_q <= inp_signed;
               end
            end
            ST_PREP: begin
               quot_neg_q <= a_neg_w ^ b_neg_w;
               rem_neg_q  <= a_neg_w;
               div_q      <= b_abs_w;
               shift_q    <= a_abs_w;
               prem_q     <= '0;
               cnt_q      <= '0;
               if (b_zero_w) begin
                  quot_q <= '1;
                  rem_q  <= a_q;
                  dbz_q  <= 1'b1;
               end else if (ovf_w) begin
                  quot_q <= MIN_VAL;
                  rem_q  <= '0;
                  dbz_q  <= 1'b0;
               end
            end
            ST_ITER: begin
               prem_q  <= step_rem_w;
               shift_q <= {shift_q[WIDTH-2:0], step_qbit_w};
               if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
            end
            ST_FIXUP: begin
               quot_q <= quot_neg_q ? -shift_q : shift_q;
               rem_q  <= rem_neg_q ? -prem_q : prem_q;
               dbz_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign inp_ready        = (state_q == ST_IDLE);
   assign outp_valid       = (state_q == ST_DONE);
   assign outp_quot        = quot_q;
   assign outp_rem         = rem_q;
   assign outp_div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_lcv_div_multi_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcv_div_multi_cycle
//  Purpose  : Self-checking bench for lcv_div_multi_cycle against a plain-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcv_div_multi_cycle;

   localparam int          W       = 32;
   localparam logic [31:0] MIN32   = 32'h8000_0000;
   localparam int          TIMEOUT = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inp_valid = 1'b0;
   logic          inp_ready;
   logic [W-1:0]  inp_a = '0;
   logic [W-1:0]  inp_b = '0;
   logic          inp_signed = 1'b0;
   logic          outp_valid;
   logic          outp_ready = 1'b0;
   logic [W-1:0]  outp_quot;
   logic [W-1:0]  outp_rem;
   logic          outp_div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lcv_div_multi_cycle #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .inp_valid        (inp_valid),
      .inp_ready        (inp_ready),
      .inp_a            (inp_a),
      .inp_b            (inp_b),
      .inp_signed       (inp_signed),
      .outp_valid       (outp_valid),
      .outp_ready       (outp_ready),
      .outp_quot        (outp_quot),
      .outp_rem         (outp_rem),
      .outp_div_by_zero (outp_div_by_zero)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r, output logic z);
      int sa, sb;
      sa = a;
      sb = b;
      z  = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; z = 1'b1;
      end else if (s && a == MIN32 && b == 32'hFFFF_FFFF) begin
         q = MIN32; r = 32'd0;
      end else if (s) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
   endfunction

   // Presents operands and returns once the accept edge has passed.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, output bit ok);
      int n = 0;
      inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
      while (!inp_ready && n < TIMEOUT) begin
         @(posedge clk); #1; n++;
      end
      ok = inp_ready;
      if (!ok) check_val("accept_timeout", 0, 1);
      @(posedge clk); #1;
      inp_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!outp_valid && lat < TIMEOUT) begin
         @(posedge clk); #1; lat++;
      end
      if (!outp_valid) check_val("valid_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit pre_rdy, input int stall, input string tag);
      logic [31:0] eq, er;
      logic        ez;
      int          lat, exp_lat;
      bit          ok;
      ref_div(a, b, s, eq, er, ez);
      exp_lat = (b == 0 || (s && a == MIN32 && b == 32'hFFFF_FFFF)) ? 1 : W + 2;
      start_op(a, b, s, ok);
      if (!ok) return;
      outp_ready = pre_rdy;
      wait_valid(lat);
      if (!outp_valid) begin
         outp_ready = 1'b0;
         return;
      end
      check_val({tag, "_lat"},  lat, exp_lat);
      check_val({tag, "_quot"}, outp_quot, eq);
      check_val({tag, "_rem"},  outp_rem, er);
      check_val({tag, "_dbz"},  outp_div_by_zero, ez);
      if (!pre_rdy) begin
         repeat (stall) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, outp_valid, 1);
            check_val({tag, "_hold_quot"},  outp_quot, eq);
         end
         outp_ready = 1'b1;
      end
      @(posedge clk); #1;
      outp_ready = 1'b0;
      check_val({tag, "_post_valid"}, outp_valid, 0);
      check_val({tag, "_post_ready"}, inp_ready, 1);
   endtask

   initial begin
      int  lat;
      bit  ok;
      logic [31:0] ra, rb;
      logic        rs;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_inp_ready", inp_ready, 1);
      check_val("rst_valid",     outp_valid, 0);
      check_val("rst_quot",      outp_quot, 0);
      check_val("rst_rem",       outp_rem, 0);
      check_val("rst_dbz",       outp_div_by_zero, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 1'b0, 1'b0, 2, "u100_7");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, "s_m7_2");
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1, "s_7_m2");
      run_op(32'd5, 32'd0, 1'b0, 1'b0, 0, "u5_0");
      run_op(MIN32, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "s_ovf");
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, 0, "s_dbz");

      // Result held under back-pressure; a busy-time operand pulse must be dropped.
      start_op(32'hFFFF_FFFF, 32'd1, 1'b0, ok);
      wait_valid(lat);
      check_val("hold_lat", lat, W + 2);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            inp_a = 32'd50; inp_b = 32'd5; inp_valid = 1'b1;
         end
         if (i == 4) inp_valid = 1'b0;
         @(posedge clk); #1;
         check_val("hold_valid", outp_valid, 1);
         check_val("hold_ready", inp_ready, 0);
         check_val("hold_quot",  outp_quot, 32'hFFFF_FFFF);
         check_val("hold_rem",   outp_rem, 0);
      end
      outp_ready = 1'b1;
      @(posedge clk); #1;
      outp_ready = 1'b0;
      check_val("rel_valid", outp_valid, 0);
      check_val("rel_ready", inp_ready, 1);
      check_val("rel_quot_kept", outp_quot, 32'hFFFF_FFFF);
      repeat (3) begin
         @(posedge clk); #1;
         check_val("no_queued_valid", outp_valid, 0);
      end

      // Asynchronous reset in the middle of the iteration phase.
      start_op(32'd1234567, 32'd89, 1'b0, ok);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_ready", inp_ready, 1);
      check_val("arst_valid", outp_valid, 0);
      check_val("arst_quot",  outp_quot, 0);
      check_val("arst_rem",   outp_rem, 0);
      check_val("arst_dbz",   outp_div_by_zero, 0);
      @(posedge clk); #1;
      check_val("arst_ready_hold", inp_ready, 1);
      rst = 1'b0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         check_val("arst_no_result", outp_valid, 0);
      end
      run_op(32'd9, 32'd3, 1'b0, 1'b0, 0, "u9_3");

      for (int n = 0; n < 1000; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = MIN32; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 255));
            4: rb = rs ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(ra, rb, rs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
